// File: rtl/serv_dbus_pkg.sv
// Shared definitions for the data-bus responder: FSM encoding and sizing constants.
package serv_dbus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_e;

    localparam int WORD_BYTES = 4;
    localparam int CNT_W      = 4;

endpackage

// File: rtl/serv_dbus_ram.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The contents are never reset.
module serv_dbus_ram
    import serv_dbus_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int AW      = $clog2(DEPTH),
    parameter     MEMFILE = ""
) (
    input  logic                  clk_i,
    input  logic [AW-1:0]         addr_i,
    input  logic [31:0]           wdata_i,
    input  logic [WORD_BYTES-1:0] we_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Write only the enabled byte lanes and register the word at the current address.
    always_ff @(posedge clk_i) begin
        for (int n = 0; n < WORD_BYTES; n++) begin
            if (we_i[n]) begin
                mem[addr_i][8*n +: 8] <= wdata_i[8*n +: 8];
            end
        end
        rdata_q <= mem[addr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/serv_dbus_responder.sv
// Wishbone classic slave on the core's data bus. Each request is captured in
// IDLE, held for WAIT_CYCLES idle cycles, then acknowledged for one cycle.
// Stores commit to the RAM at the edge that ends the ACK cycle; loads return
// the whole aligned word during the ACK cycle and zero at all other times.
module serv_dbus_responder
    import serv_dbus_pkg::*;
#(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2,
    parameter     MEMFILE     = ""
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_busy
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [AW-1:0]         adrIdx_q, adrIdx_d;
    logic [31:0]           dat_q, dat_d;
    logic [WORD_BYTES-1:0] sel_q, sel_d;
    logic                  we_q, we_d;
    logic                  ack_q, ack_d;
    logic                  busy_q, busy_d;

    logic [AW-1:0]         idxIn;
    logic [AW-1:0]         ramAddr;
    logic [WORD_BYTES-1:0] ramWe;
    logic [31:0]           ramRdata;
    logic                  unused_adr;

    // Word index straight from the bus; dropping the high bits gives the modulo-DEPTH alias.
    assign idxIn      = i_wb_adr[AW+1:2];
    assign unused_adr = ^{i_wb_adr[31:AW+2], i_wb_adr[1:0]};

    // Next-state and next-output logic for the request FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        adrIdx_d = adrIdx_q;
        dat_d    = dat_q;
        sel_d    = sel_q;
        we_d     = we_q;
        ack_d    = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (i_wb_cyc) begin
                    adrIdx_d = idxIn;
                    dat_d    = i_wb_dat;
                    sel_d    = i_wb_sel;
                    we_d     = i_wb_we;
                    cnt_d    = WAIT_LOAD;
                    busy_d   = 1'b1;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ACK;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 1'b1;
                if (!i_wb_cyc) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (cnt_q == 4'd1) begin
                    state_d = ACK;
                    ack_d   = 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, request latch and registered handshake outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            adrIdx_q <= '0;
            dat_q    <= '0;
            sel_q    <= '0;
            we_q     <= 1'b0;
            ack_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            adrIdx_q <= adrIdx_d;
            dat_q    <= dat_d;
            sel_q    <= sel_d;
            we_q     <= we_d;
            ack_q    <= ack_d;
            busy_q   <= busy_d;
        end
    end

    // In IDLE the RAM reads the incoming index so a zero-wait load has data in the
    // following ACK cycle; otherwise it reads the latched index. A store is
    // dropped if reset is asserted while it is being acknowledged.
    assign ramAddr = (state_q == IDLE) ? idxIn : adrIdx_q;
    assign ramWe   = {WORD_BYTES{(state_q == ACK) && we_q && i_rst_n}} & sel_q;

    serv_dbus_ram #(
        .DEPTH   (DEPTH),
        .AW      (AW),
        .MEMFILE (MEMFILE)
    ) u_ram (
        .clk_i   (i_clk),
        .addr_i  (ramAddr),
        .wdata_i (dat_q),
        .we_i    (ramWe),
        .rdata_o (ramRdata)
    );

    assign o_wb_ack = ack_q;
    assign o_busy   = busy_q;
    assign o_wb_rdt = ack_q ? ramRdata : 32'h0;

endmodule
